ivl_uvm_ovl_seq_gen: RTL and testbench

- Programmable event-sequence stimulus generator; sits directly upstream of ovl_cycle_sequence and drives its event_sequence input.
- Produces a walking one-hot pattern, MSB first (or reversed), with each step held a programmable number of cycles.
- Optional fault injection (skipped step) deliberately trips the checker in fail tests.
- start/busy/done handshake lets benches chain sequences without hand-written delay loops.

---
 rtl/ivl_uvm_ovl_pkg.sv | 28 ++
 rtl/ivl_uvm_ovl_seq_gen_if.sv | 26 ++
 rtl/ivl_uvm_ovl_dwell_cnt.sv | 27 ++
 rtl/ivl_uvm_ovl_seq_gen.sv | 167 ++++++++++++++++
 tb/tb_ivl_uvm_ovl_seq_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared types for the event-sequence stimulus generator.
package ivl_uvm_ovl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        INJ_NONE = 2'd0,
        INJ_SKIP = 2'd1,
        INJ_REV  = 2'd2
    } inj_mode_e;

    // Encoding 3 is not a mode of its own; it runs as a plain sequence.
    localparam logic [1:0] INJ_RESERVED = 2'd3;

    function automatic inj_mode_e decode_inj_mode(input logic [1:0] raw);
        case (raw)
            2'd1:         return INJ_SKIP;
            2'd2:         return INJ_REV;
            INJ_RESERVED: return INJ_NONE;
            default:      return INJ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ivl_uvm_ovl_seq_gen_if.sv
// Control/status bundle between a bench sequencer and the generator.
interface ivl_uvm_ovl_seq_gen_if #(
    parameter int NUM_CKS = 4,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
);
    logic                 start;
    logic [DWELL_W-1:0]   dwell;
    logic [1:0]           inj_mode;
    logic [3:0]           inj_step;
    logic [NUM_CKS-1:0]   event_sequence;
    logic                 busy;
    logic                 done;
    logic [3:0]           step_idx;
    logic [CNT_W-1:0]     seq_count;

    modport master (
        output start, dwell, inj_mode, inj_step,
        input  event_sequence, busy, done, step_idx, seq_count
    );

    modport slave (
        input  start, dwell, inj_mode, inj_step,
        output event_sequence, busy, done, step_idx, seq_count
    );
endinterface

// File: rtl/ivl_uvm_ovl_dwell_cnt.sv
// Loadable down-counter timing how long each step is held.
module ivl_uvm_ovl_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               en,
    output logic               expire
);
    logic [DWELL_W-1:0] cnt_q;

    // Load wins over counting; the count parks at zero when not reloaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Terminal count: the current cycle is the last one of the step.
    assign expire = (cnt_q == DWELL_W'(1));
endmodule

// File: rtl/ivl_uvm_ovl_seq_gen.sv
// Walking one-hot event-sequence generator with skip/reverse fault injection.
//   state | meaning
//   IDLE  | outputs quiet, waiting for start
//   STEP  | driving one step of the pattern, dwell counter running
//   DONE  | one-cycle completion pulse, seq_count bumped
module ivl_uvm_ovl_seq_gen
    import ivl_uvm_ovl_pkg::*;
#(
    parameter int NUM_CKS = 4,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    ivl_uvm_ovl_seq_gen_if.slave bus
);
    seq_state_e          state_q, state_d;
    logic [3:0]          step_q, step_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    inj_mode_e           mode_q, mode_d;
    logic [3:0]          skip_q, skip_d;
    logic [NUM_CKS-1:0]  event_q, event_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                cnt_load;
    logic [DWELL_W-1:0]  cnt_load_val;
    logic                cnt_expire;
    logic [DWELL_W-1:0]  dwell_eff;
    inj_mode_e           mode_in;
    logic [4:0]          first_step;
    logic [4:0]          next_step;

    // First logical step at or after 'from' that is not skipped; NUM_CKS if none remain.
    function automatic logic [4:0] find_step(input logic [4:0] from,
                                             input inj_mode_e  mode,
                                             input logic [3:0] skip);
        logic [4:0] r;
        r = 5'(NUM_CKS);
        for (int i = NUM_CKS - 1; i >= 0; i--) begin
            if ((5'(i) >= from) && !((mode == INJ_SKIP) && (4'(i) == skip))) begin
                r = 5'(i);
            end
        end
        return r;
    endfunction

    // Logical step k lights bit NUM_CKS-1-k, or bit k when running reversed.
    function automatic logic [NUM_CKS-1:0] step_onehot(input logic [4:0] k, input logic rev);
        logic [NUM_CKS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_CKS; i++) begin
            if (5'(i) == k) begin
                if (rev) v[i] = 1'b1;
                else     v[NUM_CKS-1-i] = 1'b1;
            end
        end
        return v;
    endfunction

    assign dwell_eff    = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign mode_in      = decode_inj_mode(bus.inj_mode);
    assign first_step   = find_step(5'd0, mode_in, bus.inj_step);
    assign next_step    = find_step({1'b0, step_q} + 5'd1, mode_q, skip_q);
    assign cnt_load_val = (state_q == IDLE) ? dwell_eff : dwell_q;

    ivl_uvm_ovl_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (state_q == STEP),
        .expire   (cnt_expire)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        dwell_d  = dwell_q;
        mode_d   = mode_q;
        skip_d   = skip_q;
        event_d  = event_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        count_d  = count_q;
        cnt_load = 1'b0;

        case (state_q)
            IDLE: begin
                event_d = '0;
                busy_d  = 1'b0;
                step_d  = '0;
                if (bus.start) begin
                    dwell_d  = dwell_eff;
                    mode_d   = mode_in;
                    skip_d   = bus.inj_step;
                    step_d   = first_step[3:0];
                    event_d  = step_onehot(first_step, mode_in == INJ_REV);
                    busy_d   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = STEP;
                end
            end
            STEP: begin
                if (cnt_expire) begin
                    cnt_load = 1'b1;
                    if (next_step == 5'(NUM_CKS)) begin
                        state_d = DONE;
                        step_d  = '0;
                        event_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (count_q != '1) count_d = count_q + 1'b1;
                    end else begin
                        step_d  = next_step[3:0];
                        event_d = step_onehot(next_step, mode_q == INJ_REV);
                    end
                end
            end
            DONE: begin
                event_d = '0;
                busy_d  = 1'b0;
                step_d  = '0;
                state_d = IDLE;
            end
            default: begin
                event_d = '0;
                busy_d  = 1'b0;
                step_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State, latched configuration and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            dwell_q <= DWELL_W'(1);
            mode_q  <= INJ_NONE;
            skip_q  <= '0;
            event_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            mode_q  <= mode_d;
            skip_q  <= skip_d;
            event_q <= event_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign bus.event_sequence = event_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.step_idx       = step_q;
    assign bus.seq_count      = count_q;
endmodule

// File: tb/tb_ivl_uvm_ovl_seq_gen.sv
// Directed, table-driven bench for the event-sequence generator (NUM_CKS = 4).
module tb_ivl_uvm_ovl_seq_gen;
    logic clk;
    logic rst;

    ivl_uvm_ovl_seq_gen_if #(.NUM_CKS(4), .DWELL_W(8), .CNT_W(16)) bus ();

    ivl_uvm_ovl_seq_gen #(.NUM_CKS(4), .DWELL_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector = one full sequence. ev/idx hold one nibble per cycle,
    // nibble 0 (rightmost) being the first cycle after start is sampled.
    typedef struct {
        logic [7:0]  dwell;
        logic [1:0]  mode;
        logic [3:0]  inj;
        int          len;
        logic [63:0] ev;
        logic [63:0] idx;
    } vec_t;

    vec_t vecs[8];
    int   errors;
    int   checks;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_vec(input int n, input logic [7:0] dw, input logic [1:0] md,
                           input logic [3:0] inj, input int len,
                           input logic [63:0] ev, input logic [63:0] idx);
        vecs[n].dwell = dw;
        vecs[n].mode  = md;
        vecs[n].inj   = inj;
        vecs[n].len   = len;
        vecs[n].ev    = ev;
        vecs[n].idx   = idx;
    endtask

    // Start a sequence, scramble the inputs once it is accepted, and check every cycle.
    task automatic run_vec(input int n, input int exp_cnt);
        bus.start    = 1'b1;
        bus.dwell    = vecs[n].dwell;
        bus.inj_mode = vecs[n].mode;
        bus.inj_step = vecs[n].inj;
        for (int c = 0; c < vecs[n].len; c++) begin
            tick();
            if (c == 0) begin
                bus.start    = 1'b0;
                bus.dwell    = 8'd7;
                bus.inj_mode = 2'd2;
                bus.inj_step = 4'd0;
            end
            chk($sformatf("v%0d c%0d event", n, c), 32'(bus.event_sequence), 32'(vecs[n].ev[4*c +: 4]));
            chk($sformatf("v%0d c%0d step_idx", n, c), 32'(bus.step_idx), 32'(vecs[n].idx[4*c +: 4]));
            chk($sformatf("v%0d c%0d busy", n, c), 32'(bus.busy), 32'd1);
            chk($sformatf("v%0d c%0d done", n, c), 32'(bus.done), 32'd0);
        end
        tick();
        chk($sformatf("v%0d done pulse", n), 32'(bus.done), 32'd1);
        chk($sformatf("v%0d done busy", n), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d done event", n), 32'(bus.event_sequence), 32'd0);
        chk($sformatf("v%0d done step_idx", n), 32'(bus.step_idx), 32'd0);
        chk($sformatf("v%0d seq_count", n), 32'(bus.seq_count), 32'(exp_cnt));
        tick();
        chk($sformatf("v%0d idle done", n), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d idle busy", n), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dwell    = 8'd0;
        bus.inj_mode = 2'd0;
        bus.inj_step = 4'd0;

        set_vec(0, 8'd2, 2'd0, 4'd0, 8,  64'h1122_4488,     64'h3322_1100);
        set_vec(1, 8'd0, 2'd0, 4'd0, 4,  64'h1248,          64'h3210);
        set_vec(2, 8'd2, 2'd1, 4'd1, 6,  64'h11_2288,       64'h33_2200);
        set_vec(3, 8'd1, 2'd2, 4'd0, 4,  64'h8421,          64'h3210);
        set_vec(4, 8'd1, 2'd1, 4'd3, 3,  64'h248,           64'h210);
        set_vec(5, 8'd1, 2'd1, 4'd0, 3,  64'h124,           64'h321);
        set_vec(6, 8'd1, 2'd1, 4'd9, 4,  64'h1248,          64'h3210);
        set_vec(7, 8'd3, 2'd3, 4'd1, 12, 64'h111_222_444_888, 64'h333_222_111_000);

        repeat (2) tick();
        chk("reset event", 32'(bus.event_sequence), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset step_idx", 32'(bus.step_idx), 32'd0);
        chk("reset seq_count", 32'(bus.seq_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle event", 32'(bus.event_sequence), 32'd0);

        for (int n = 0; n < 8; n++) run_vec(n, n + 1);

        // start pulsed mid-sequence and during the done cycle must not restart
        bus.start    = 1'b1;
        bus.dwell    = 8'd1;
        bus.inj_mode = 2'd0;
        tick();
        bus.start = 1'b0;
        chk("restart c0 event", 32'(bus.event_sequence), 32'h8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart c1 event", 32'(bus.event_sequence), 32'h4);
        tick();
        chk("restart c2 event", 32'(bus.event_sequence), 32'h2);
        tick();
        chk("restart c3 event", 32'(bus.event_sequence), 32'h1);
        tick();
        chk("restart done", 32'(bus.done), 32'd1);
        chk("restart count", 32'(bus.seq_count), 32'd9);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start in done busy", 32'(bus.busy), 32'd0);
        chk("start in done event", 32'(bus.event_sequence), 32'd0);
        tick();
        chk("after done busy", 32'(bus.busy), 32'd0);
        chk("after done count", 32'(bus.seq_count), 32'd9);

        // async reset while step 2 is showing, then a clean rerun
        bus.start    = 1'b1;
        bus.dwell    = 8'd2;
        bus.inj_mode = 2'd0;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        chk("pre-reset event", 32'(bus.event_sequence), 32'h2);
        chk("pre-reset step_idx", 32'(bus.step_idx), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset event", 32'(bus.event_sequence), 32'd0);
        chk("async reset busy", 32'(bus.busy), 32'd0);
        chk("async reset step_idx", 32'(bus.step_idx), 32'd0);
        chk("async reset count", 32'(bus.seq_count), 32'd0);
        rst = 1'b0;
        tick();
        chk("post-reset idle busy", 32'(bus.busy), 32'd0);
        run_vec(0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
